// File: rtl/parallel_or_gather.sv
// parallel_or_gather: packs WAY beats of WIRE bits into a frame laid out for per-wire OR reduction
module parallel_or_gather #(
  parameter  int WAY  = 2,
  parameter  int WIRE = 2,
  localparam int SIZE = WAY * WIRE,
  localparam int CW   = $clog2(WAY + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WIRE-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW-1:0]   out_count
);
  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;
  state_t          state_q, state_d;
  logic [SIZE-1:0] data_q, data_d;
  logic [CW-1:0]   count_q, count_d;
  logic            acc;
  assign in_ready  = state_q != FULL;
  assign out_valid = state_q == FULL;
  assign out_data  = data_q;
  assign out_count = count_q;
  assign acc       = in_valid && in_ready;
  // next state: scatter the beat into column count_q, close on last beat or flush, clear on transfer
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    if (acc) begin
      for (int i = 0; i < WIRE; i++)
        for (int k = 0; k < WAY; k++)
          if (count_q == CW'(k)) data_d[i*WAY+k] = in_data[i];
      count_d = count_q + CW'(1);
      state_d = (count_q == CW'(WAY - 1) || (flush && state_q == FILL)) ? FULL : FILL;
    end else if (flush && state_q == FILL) begin
      state_d = FULL;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
      data_d  = '0;
      count_d = '0;
    end
  end
  // state register; reset discards any partial or held frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_parallel_or_gather.sv
// tb_parallel_or_gather: directed checks of frame packing, flush, backpressure and reset
module tb_parallel_or_gather;
  logic       clk = 0;
  logic       reset = 1;
  logic [1:0] in_data = '0;
  logic       in_valid = 0, flush = 0, out_ready = 0;
  logic       in_ready, out_valid;
  logic [5:0] out_data;
  logic [1:0] out_count;
  logic [0:0] in_data2 = '0;
  logic       in_valid2 = 0, flush2 = 0, out_ready2 = 0;
  logic       in_ready2, out_valid2;
  logic [1:0] out_data2;
  logic [1:0] out_count2;
  int         n_chk = 0, n_fail = 0;

  parallel_or_gather #(.WAY(3), .WIRE(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count)
  );

  parallel_or_gather #(.WAY(2), .WIRE(1)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .flush(flush2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_count(out_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] d, input logic f);
    in_data  = d;
    in_valid = 1;
    flush    = f;
    tick();
    in_valid = 0;
    flush    = 0;
  endtask

  task automatic idle_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_count"}, 32'(out_count), 0);
    chk({tag, "_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    tick();
    tick();
    idle_state("reset");
    reset = 0;
    // full frame with out_ready high
    out_ready = 1;
    beat(2'b01, 0);
    chk("ff_cnt1", 32'(out_count), 1);
    chk("ff_rdy1", 32'(in_ready), 1);
    beat(2'b10, 0);
    beat(2'b11, 0);
    chk("ff_valid", 32'(out_valid), 1);
    chk("ff_data", 32'(out_data), 32'(6'b110101));
    chk("ff_count", 32'(out_count), 3);
    chk("ff_rdy", 32'(in_ready), 0);
    chk("ff_or", 32'({|out_data[5:3], |out_data[2:0]}), 32'(2'b11));
    tick();
    idle_state("ff_drain");
    // flush a partial frame
    out_ready = 0;
    beat(2'b10, 0);
    chk("fp_cnt1", 32'(out_count), 1);
    chk("fp_valid0", 32'(out_valid), 0);
    flush = 1;
    tick();
    flush = 0;
    chk("fp_valid", 32'(out_valid), 1);
    chk("fp_data", 32'(out_data), 32'(6'b001000));
    chk("fp_count", 32'(out_count), 1);
    out_ready = 1;
    tick();
    idle_state("fp_drain");
    // flush together with a beat
    out_ready = 0;
    beat(2'b01, 0);
    beat(2'b11, 1);
    chk("fb_valid", 32'(out_valid), 1);
    chk("fb_data", 32'(out_data), 32'(6'b010011));
    chk("fb_count", 32'(out_count), 2);
    out_ready = 1;
    tick();
    idle_state("fb_drain");
    // backpressure while full
    out_ready = 0;
    beat(2'b11, 0);
    beat(2'b00, 0);
    beat(2'b10, 0);
    for (int c = 0; c < 4; c++) begin
      in_valid = 1;
      in_data  = 2'(c);
      tick();
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_data", 32'(out_data), 32'(6'b101001));
      chk("bp_count", 32'(out_count), 3);
    end
    in_data   = 2'b01;
    out_ready = 1;
    tick();
    in_valid  = 0;
    idle_state("bp_xfer");
    tick();
    idle_state("bp_after");
    // asynchronous reset in the middle of a frame
    out_ready = 0;
    beat(2'b01, 0);
    beat(2'b10, 0);
    chk("rm_cnt2", 32'(out_count), 2);
    #3 reset = 1;
    #1 idle_state("rm_async");
    #1 reset = 0;
    beat(2'b10, 0);
    beat(2'b10, 0);
    beat(2'b01, 0);
    chk("rm_valid", 32'(out_valid), 1);
    chk("rm_data", 32'(out_data), 32'(6'b011100));
    chk("rm_count", 32'(out_count), 3);
    out_ready = 1;
    tick();
    idle_state("rm_drain");
    // WAY=2, WIRE=1: idle flush then a two-beat frame
    flush2 = 1;
    tick();
    flush2 = 0;
    chk("w2_flush_valid", 32'(out_valid2), 0);
    chk("w2_flush_count", 32'(out_count2), 0);
    chk("w2_flush_ready", 32'(in_ready2), 1);
    in_valid2 = 1;
    in_data2  = 1'b1;
    tick();
    chk("w2_cnt1", 32'(out_count2), 1);
    in_data2  = 1'b0;
    tick();
    in_valid2 = 0;
    chk("w2_valid", 32'(out_valid2), 1);
    chk("w2_data", 32'(out_data2), 32'(2'b01));
    chk("w2_count", 32'(out_count2), 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
